eth_idma_reg_frontend: RTL and testbench

Register-bus front end for the Ethernet iDMA backend. Software programs one transfer descriptor through the 32-bit register bus, and a write of GO issues a single `idma_req_t` with a valid/ready handshake. The block counts outstanding transfers, retires `idma_rsp_t` responses, captures the first error and raises a completion interrupt. It sits directly upstream of the iDMA backend and drives its request port.

---
 rtl/eth_idma_pkg.sv | 101 ++++++++++
 rtl/eth_idma_reg_frontend_if.sv | 24 ++
 rtl/eth_idma_reg_decode.sv | 59 +++++
 rtl/eth_idma_reg_frontend.sv | 157 +++++++++++++++
 tb/tb_eth_idma_reg_frontend.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_idma_pkg.sv
// Shared types, register map and bit positions for the Ethernet iDMA register front end.
package eth_idma_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_bus_rsp_t;

  typedef struct packed {
    logic [2:0] src_protocol;
    logic [2:0] dst_protocol;
    logic [1:0] burst;
    logic [3:0] cache;
    logic       decouple_rw;
    logic       last;
  } idma_opt_t;

  typedef struct packed {
    logic [31:0] length;
    logic [63:0] src_addr;
    logic [63:0] dst_addr;
    idma_opt_t   opt;
  } idma_req_t;

  typedef struct packed {
    logic [3:0]  cause;
    logic [1:0]  err_type;
    logic [63:0] burst_addr;
  } idma_err_payload_t;

  typedef struct packed {
    logic              last;
    logic              error;
    idma_err_payload_t pld;
  } idma_rsp_t;

  typedef enum logic {
    FE_IDLE,
    FE_PEND
  } eth_idma_fe_state_e;

  localparam logic [31:0] ETH_IDMA_REG_SRC_LO      = 32'h00;
  localparam logic [31:0] ETH_IDMA_REG_SRC_HI      = 32'h04;
  localparam logic [31:0] ETH_IDMA_REG_DST_LO      = 32'h08;
  localparam logic [31:0] ETH_IDMA_REG_DST_HI      = 32'h0C;
  localparam logic [31:0] ETH_IDMA_REG_LEN         = 32'h10;
  localparam logic [31:0] ETH_IDMA_REG_PROTO       = 32'h14;
  localparam logic [31:0] ETH_IDMA_REG_CTRL        = 32'h18;
  localparam logic [31:0] ETH_IDMA_REG_STATUS      = 32'h1C;
  localparam logic [31:0] ETH_IDMA_REG_DONE_CNT    = 32'h20;
  localparam logic [31:0] ETH_IDMA_REG_ISSUE_CNT   = 32'h24;
  localparam logic [31:0] ETH_IDMA_REG_ERR_ADDR_LO = 32'h28;
  localparam logic [31:0] ETH_IDMA_REG_ERR_ADDR_HI = 32'h2C;

  localparam int unsigned ETH_IDMA_NUM_REGS = 12;

  // Word indices used by the decoder and read mux.
  localparam int unsigned ETH_IDMA_IDX_SRC_LO      = ETH_IDMA_REG_SRC_LO >> 2;
  localparam int unsigned ETH_IDMA_IDX_SRC_HI      = ETH_IDMA_REG_SRC_HI >> 2;
  localparam int unsigned ETH_IDMA_IDX_DST_LO      = ETH_IDMA_REG_DST_LO >> 2;
  localparam int unsigned ETH_IDMA_IDX_DST_HI      = ETH_IDMA_REG_DST_HI >> 2;
  localparam int unsigned ETH_IDMA_IDX_LEN         = ETH_IDMA_REG_LEN >> 2;
  localparam int unsigned ETH_IDMA_IDX_PROTO       = ETH_IDMA_REG_PROTO >> 2;
  localparam int unsigned ETH_IDMA_IDX_CTRL        = ETH_IDMA_REG_CTRL >> 2;
  localparam int unsigned ETH_IDMA_IDX_STATUS      = ETH_IDMA_REG_STATUS >> 2;
  localparam int unsigned ETH_IDMA_IDX_DONE_CNT    = ETH_IDMA_REG_DONE_CNT >> 2;
  localparam int unsigned ETH_IDMA_IDX_ISSUE_CNT   = ETH_IDMA_REG_ISSUE_CNT >> 2;
  localparam int unsigned ETH_IDMA_IDX_ERR_ADDR_LO = ETH_IDMA_REG_ERR_ADDR_LO >> 2;
  localparam int unsigned ETH_IDMA_IDX_ERR_ADDR_HI = ETH_IDMA_REG_ERR_ADDR_HI >> 2;

  localparam int unsigned ETH_IDMA_CTRL_GO      = 0;
  localparam int unsigned ETH_IDMA_CTRL_IRQ_CLR = 1;
  localparam int unsigned ETH_IDMA_CTRL_IRQ_EN  = 2;
  localparam int unsigned ETH_IDMA_CTRL_ERR_CLR = 3;

  localparam int unsigned ETH_IDMA_STATUS_BUSY     = 0;
  localparam int unsigned ETH_IDMA_STATUS_REQ_PEND = 1;
  localparam int unsigned ETH_IDMA_STATUS_ERR      = 2;
  localparam int unsigned ETH_IDMA_STATUS_OUTST    = 8;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/eth_idma_reg_frontend_if.sv
// Register bus plus iDMA request/response handshakes of the front end.
interface eth_idma_reg_frontend_if
  import eth_idma_pkg::*;
();
  reg_bus_req_t reg_req_i;
  reg_bus_rsp_t reg_rsp_o;
  idma_req_t    idma_req_o;
  logic         req_valid_o;
  logic         req_ready_i;
  idma_rsp_t    idma_rsp_i;
  logic         rsp_valid_i;
  logic         rsp_ready_o;

  // slave: the front end itself; master: the CPU/backend environment around it.
  modport slave (
    input  reg_req_i, req_ready_i, idma_rsp_i, rsp_valid_i,
    output reg_rsp_o, idma_req_o, req_valid_o, rsp_ready_o
  );

  modport master (
    output reg_req_i, req_ready_i, idma_rsp_i, rsp_valid_i,
    input  reg_rsp_o, idma_req_o, req_valid_o, rsp_ready_o
  );
endinterface

// File: rtl/eth_idma_reg_decode.sv
// Combinational register decode: write enables, CTRL actions, read mux and bus error.
module eth_idma_reg_decode
  import eth_idma_pkg::*;
(
  input  reg_bus_req_t                         reg_req,
  input  logic                                 pend,
  input  logic                                 go_ok,
  input  logic [ETH_IDMA_NUM_REGS-1:0][31:0]   rd_regs,
  output reg_bus_rsp_t                         reg_rsp,
  output logic [ETH_IDMA_NUM_REGS-1:0]         wr_en,
  output logic                                 go,
  output logic                                 irq_clr,
  output logic                                 irq_en_we,
  output logic                                 err_clr
);

  logic [3:0] idx;
  logic       mapped;
  logic       unused_bits;

  assign idx         = reg_req.addr[5:2];
  assign mapped      = (reg_req.addr[31:6] == '0) && (idx < 4'(ETH_IDMA_NUM_REGS));
  assign unused_bits = ^{reg_req.addr[1:0], reg_req.wdata[31:4], reg_req.wstrb[3:1]};

  always_comb begin
    reg_rsp       = '0;
    reg_rsp.ready = 1'b1;
    wr_en         = '0;
    go            = 1'b0;
    irq_clr       = 1'b0;
    irq_en_we     = 1'b0;
    err_clr       = 1'b0;

    if (reg_req.valid) begin
      if (!mapped) begin
        reg_rsp.error = 1'b1;
      end else if (reg_req.write) begin
        if (idx <= 4'(ETH_IDMA_IDX_PROTO)) begin
          // The descriptor is frozen while a request is waiting on the backend.
          if (pend) reg_rsp.error = 1'b1;
          else      wr_en[idx]    = 1'b1;
        end else if (idx == 4'(ETH_IDMA_IDX_CTRL) && reg_req.wstrb[0]) begin
          // A rejected GO drops the whole CTRL write.
          if (reg_req.wdata[ETH_IDMA_CTRL_GO] && !go_ok) begin
            reg_rsp.error = 1'b1;
          end else begin
            go        = reg_req.wdata[ETH_IDMA_CTRL_GO];
            irq_clr   = reg_req.wdata[ETH_IDMA_CTRL_IRQ_CLR];
            irq_en_we = 1'b1;
            err_clr   = reg_req.wdata[ETH_IDMA_CTRL_ERR_CLR];
          end
        end
      end else begin
        reg_rsp.rdata = rd_regs[idx];
      end
    end
  end

endmodule

// File: rtl/eth_idma_reg_frontend.sv
// Register front end for the Ethernet iDMA backend: descriptor registers, single-request
// issue FSM, outstanding tracking, response retirement, error capture and interrupt.
module eth_idma_reg_frontend
  import eth_idma_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  eth_idma_reg_frontend_if.slave   bus,
  output logic                     busy_o,
  output logic                     irq_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  typedef logic [OutW-1:0] out_cnt_t;

  eth_idma_fe_state_e state_q, state_d;
  logic [63:0] src_q, dst_q, err_addr_q;
  logic [31:0] len_q, done_cnt_q, issue_cnt_q;
  logic [5:0]  proto_q;
  logic        irq_en_q, irq_pending_q, err_sticky_q;
  out_cnt_t    outstanding_q, outstanding_d;
  idma_req_t   req_q, req_d;

  logic [ETH_IDMA_NUM_REGS-1:0]       wr_en;
  logic [ETH_IDMA_NUM_REGS-1:0][31:0] rd_regs;
  logic        go, irq_clr, irq_en_we, err_clr, go_ok;
  logic        req_valid, req_hs, rsp_hs, rsp_err;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        unused_rsp;

  assign wdata      = bus.reg_req_i.wdata;
  assign wstrb      = bus.reg_req_i.wstrb;
  assign req_valid  = (state_q == FE_PEND);
  assign req_hs     = req_valid && bus.req_ready_i;
  assign rsp_hs     = bus.rsp_valid_i;
  assign rsp_err    = rsp_hs && bus.idma_rsp_i.error;
  assign go_ok      = (state_q == FE_IDLE) && (outstanding_q < out_cnt_t'(MaxOutstanding))
                      && (len_q != '0);
  assign unused_rsp = ^{bus.idma_rsp_i.last, bus.idma_rsp_i.pld.cause,
                        bus.idma_rsp_i.pld.err_type};

  eth_idma_reg_decode u_decode (
    .reg_req   (bus.reg_req_i),
    .pend      (req_valid),
    .go_ok     (go_ok),
    .rd_regs   (rd_regs),
    .reg_rsp   (bus.reg_rsp_o),
    .wr_en     (wr_en),
    .go        (go),
    .irq_clr   (irq_clr),
    .irq_en_we (irq_en_we),
    .err_clr   (err_clr)
  );

  // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    rd_regs                           = '0;
    rd_regs[ETH_IDMA_IDX_SRC_LO]      = src_q[31:0];
    rd_regs[ETH_IDMA_IDX_SRC_HI]      = src_q[63:32];
    rd_regs[ETH_IDMA_IDX_DST_LO]      = dst_q[31:0];
    rd_regs[ETH_IDMA_IDX_DST_HI]      = dst_q[63:32];
    rd_regs[ETH_IDMA_IDX_LEN]         = len_q;
    rd_regs[ETH_IDMA_IDX_PROTO]       = {26'b0, proto_q};
    rd_regs[ETH_IDMA_IDX_STATUS]      = {16'b0, 8'(outstanding_q), 5'b0,
                                         err_sticky_q, req_valid, busy_o};
    rd_regs[ETH_IDMA_IDX_DONE_CNT]    = done_cnt_q;
    rd_regs[ETH_IDMA_IDX_ISSUE_CNT]   = issue_cnt_q;
    rd_regs[ETH_IDMA_IDX_ERR_ADDR_LO] = err_addr_q[31:0];
    rd_regs[ETH_IDMA_IDX_ERR_ADDR_HI] = err_addr_q[63:32];
  end

  always_comb begin
    req_d                  = '0;
    req_d.length           = len_q;
    req_d.src_addr         = src_q;
    req_d.dst_addr         = dst_q;
    req_d.opt.src_protocol = proto_q[2:0];
    req_d.opt.dst_protocol = proto_q[5:3];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FE_IDLE: if (go)              state_d = FE_PEND;
      FE_PEND: if (bus.req_ready_i) state_d = FE_IDLE;
    endcase
  end

  // A response with nothing outstanding saturates at zero instead of wrapping.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({req_hs, rsp_hs})
      2'b10:   outstanding_d = outstanding_q + out_cnt_t'(1);
      2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - out_cnt_t'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= FE_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      proto_q       <= '0;
      req_q         <= '0;
      issue_cnt_q   <= '0;
      done_cnt_q    <= '0;
      outstanding_q <= '0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;

      if (wr_en[ETH_IDMA_IDX_SRC_LO]) src_q[31:0]  <= apply_wstrb(src_q[31:0], wdata, wstrb);
      if (wr_en[ETH_IDMA_IDX_SRC_HI]) src_q[63:32] <= apply_wstrb(src_q[63:32], wdata, wstrb);
      if (wr_en[ETH_IDMA_IDX_DST_LO]) dst_q[31:0]  <= apply_wstrb(dst_q[31:0], wdata, wstrb);
      if (wr_en[ETH_IDMA_IDX_DST_HI]) dst_q[63:32] <= apply_wstrb(dst_q[63:32], wdata, wstrb);
      if (wr_en[ETH_IDMA_IDX_LEN])    len_q        <= apply_wstrb(len_q, wdata, wstrb);
      if (wr_en[ETH_IDMA_IDX_PROTO])  proto_q      <= 6'(apply_wstrb({26'b0, proto_q}, wdata, wstrb));

      if (go)        req_q       <= req_d;
      if (req_hs)    issue_cnt_q <= issue_cnt_q + 32'd1;
      if (rsp_hs)    done_cnt_q  <= done_cnt_q + 32'd1;
      if (irq_en_we) irq_en_q    <= wdata[ETH_IDMA_CTRL_IRQ_EN];

      if (rsp_hs)       irq_pending_q <= 1'b1;
      else if (irq_clr) irq_pending_q <= 1'b0;

      // Only the first error is kept; a fresh error beats a simultaneous clear.
      if (rsp_err && (!err_sticky_q || err_clr)) begin
        err_sticky_q <= 1'b1;
        err_addr_q   <= bus.idma_rsp_i.pld.burst_addr;
      end else if (err_clr) begin
        err_sticky_q <= 1'b0;
        err_addr_q   <= '0;
      end
    end
  end

  assign bus.idma_req_o  = req_q;
  assign bus.req_valid_o = req_valid;
  assign bus.rsp_ready_o = 1'b1;
  assign busy_o          = req_valid || (outstanding_q != '0);
  assign irq_o           = irq_pending_q && irq_en_q;

  rsp_without_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_hs && !req_hs && outstanding_q == '0));

endmodule

// File: tb/tb_eth_idma_reg_frontend.sv
// Directed bench for eth_idma_reg_frontend; issued requests are checked against a scoreboard queue.
module tb_eth_idma_reg_frontend;
  import eth_idma_pkg::*;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  logic busy, irq;

  eth_idma_reg_frontend_if bus ();

  eth_idma_reg_frontend #(.MaxOutstanding(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  idma_req_t exp_req_q[$];

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, 192'(obs), 192'(exp));
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check(tag, 192'(obs), 192'(exp));
  endtask

  function automatic idma_req_t make_req(input logic [63:0] src, input logic [63:0] dst,
                                         input logic [31:0] len, input logic [5:0] proto);
    idma_req_t r;
    r                  = '0;
    r.length           = len;
    r.src_addr         = src;
    r.dst_addr         = dst;
    r.opt.src_protocol = proto[2:0];
    r.opt.dst_protocol = proto[5:3];
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic err);
    bus.reg_req_i = '{valid: 1'b1, write: 1'b1, addr: addr, wdata: data, wstrb: strb};
    #2 err = bus.reg_rsp_o.error;
    step(1);
    bus.reg_req_i = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    bus.reg_req_i = '{valid: 1'b1, write: 1'b0, addr: addr, wdata: 32'h0, wstrb: 4'h0};
    #2;
    data = bus.reg_rsp_o.rdata;
    err  = bus.reg_rsp_o.error;
    step(1);
    bus.reg_req_i = '0;
  endtask

  task automatic wr_ok(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic err;
    bus_write(addr, data, 4'hF, err);
    check1(tag, err, 1'b0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] data;
    logic        err;
    bus_read(addr, data, err);
    check32(tag, data, exp);
  endtask

  task automatic send_rsp(input logic err, input logic [63:0] addr);
    idma_rsp_t r;
    r                = '0;
    r.error          = err;
    r.pld.burst_addr = addr;
    bus.idma_rsp_i   = r;
    bus.rsp_valid_i  = 1'b1;
    step(1);
    bus.rsp_valid_i  = 1'b0;
    bus.idma_rsp_i   = '0;
  endtask

  // Scoreboard side: every request handshake must match the oldest expected descriptor.
  always @(negedge clk) begin
    if (!rst_i && bus.req_valid_o && bus.req_ready_i) begin
      check1("req_expected", exp_req_q.size() != 0, 1'b1);
      if (exp_req_q.size() != 0)
        check("req_content", 192'(bus.idma_req_o), 192'(exp_req_q.pop_front()));
    end
  end

  initial begin
    idma_req_t   t1_req;
    logic        err;
    logic [31:0] data;

    bus.reg_req_i   = '0;
    bus.req_ready_i = 1'b0;
    bus.idma_rsp_i  = '0;
    bus.rsp_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    check1("rst_req_valid", bus.req_valid_o, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_irq", irq, 1'b0);
    check1("rst_rsp_ready", bus.rsp_ready_o, 1'b1);
    check("rst_idma_req", 192'(bus.idma_req_o), 192'(0));
    rd_check("rst_status", ETH_IDMA_REG_STATUS, 32'h0);
    rd_check("rst_done", ETH_IDMA_REG_DONE_CNT, 32'h0);
    rd_check("rst_src_lo", ETH_IDMA_REG_SRC_LO, 32'h0);

    // Program descriptor, check per-byte strobes on LEN
    wr_ok("wr_src_lo", ETH_IDMA_REG_SRC_LO, 32'h0000_1000);
    wr_ok("wr_src_hi", ETH_IDMA_REG_SRC_HI, 32'h0);
    wr_ok("wr_dst_lo", ETH_IDMA_REG_DST_LO, 32'h8000_0000);
    wr_ok("wr_dst_hi", ETH_IDMA_REG_DST_HI, 32'h0);
    wr_ok("wr_len", ETH_IDMA_REG_LEN, 32'd64);
    wr_ok("wr_proto", ETH_IDMA_REG_PROTO, 32'h0A);
    wr_ok("wr_irq_en", ETH_IDMA_REG_CTRL, 32'h4);
    bus_write(ETH_IDMA_REG_LEN, 32'hFFFF_FFFF, 4'b0010, err);
    rd_check("len_wstrb", ETH_IDMA_REG_LEN, 32'h0000_FF40);
    wr_ok("wr_len_restore", ETH_IDMA_REG_LEN, 32'd64);

    // GO with a 3-cycle stall
    t1_req = make_req(64'h1000, 64'h8000_0000, 32'd64, 6'h0A);
    exp_req_q.push_back(t1_req);
    bus_write(ETH_IDMA_REG_CTRL, 32'h5, 4'hF, err);
    check1("go_accept", err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check1("stall_valid", bus.req_valid_o, 1'b1);
      check("stall_stable", 192'(bus.idma_req_o), 192'(t1_req));
      step(1);
    end
    bus.req_ready_i = 1'b1;
    check1("hs_valid", bus.req_valid_o, 1'b1);
    check("hs_stable", 192'(bus.idma_req_o), 192'(t1_req));
    step(1);
    bus.req_ready_i = 1'b0;
    check1("valid_drop", bus.req_valid_o, 1'b0);
    check1("busy_outstanding", busy, 1'b1);
    check1("irq_before_rsp", irq, 1'b0);
    rd_check("issue_1", ETH_IDMA_REG_ISSUE_CNT, 32'd1);
    rd_check("status_out1", ETH_IDMA_REG_STATUS, 32'h0000_0101);
    send_rsp(1'b0, 64'h0);
    check1("irq_after_rsp", irq, 1'b1);
    rd_check("done_1", ETH_IDMA_REG_DONE_CNT, 32'd1);
    rd_check("status_idle", ETH_IDMA_REG_STATUS, 32'h0);
    wr_ok("irq_clr", ETH_IDMA_REG_CTRL, 32'h6);
    check1("irq_cleared", irq, 1'b0);

    // Fill to MaxOutstanding, then a rejected 5th GO
    bus.req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_ok("fill_len", ETH_IDMA_REG_LEN, 32'(16 * (i + 1)));
      exp_req_q.push_back(make_req(64'h1000, 64'h8000_0000, 32'(16 * (i + 1)), 6'h0A));
      wr_ok("fill_go", ETH_IDMA_REG_CTRL, 32'h5);
      step(1);
    end
    rd_check("issue_5", ETH_IDMA_REG_ISSUE_CNT, 32'd5);
    rd_check("status_full", ETH_IDMA_REG_STATUS, 32'h0000_0401);
    bus_write(ETH_IDMA_REG_CTRL, 32'h5, 4'hF, err);
    check1("go_full_err", err, 1'b1);
    check1("go_full_no_valid", bus.req_valid_o, 1'b0);
    rd_check("issue_still_5", ETH_IDMA_REG_ISSUE_CNT, 32'd5);
    rd_check("status_still_full", ETH_IDMA_REG_STATUS, 32'h0000_0401);
    for (int i = 0; i < 3; i++) send_rsp(1'b0, 64'h0);
    rd_check("done_4", ETH_IDMA_REG_DONE_CNT, 32'd4);
    rd_check("status_out1b", ETH_IDMA_REG_STATUS, 32'h0000_0101);

    // Request and response handshakes in the same cycle
    exp_req_q.push_back(make_req(64'h1000, 64'h8000_0000, 32'd64, 6'h0A));
    wr_ok("same_go", ETH_IDMA_REG_CTRL, 32'h5);
    bus.idma_rsp_i  = '0;
    bus.rsp_valid_i = 1'b1;
    step(1);
    bus.rsp_valid_i = 1'b0;
    rd_check("same_status", ETH_IDMA_REG_STATUS, 32'h0000_0101);
    rd_check("same_issue", ETH_IDMA_REG_ISSUE_CNT, 32'd6);
    rd_check("same_done", ETH_IDMA_REG_DONE_CNT, 32'd5);
    send_rsp(1'b0, 64'h0);

    // First error is sticky, ERR_CLR clears it
    for (int i = 0; i < 2; i++) begin
      exp_req_q.push_back(make_req(64'h1000, 64'h8000_0000, 32'd64, 6'h0A));
      wr_ok("err_go", ETH_IDMA_REG_CTRL, 32'h5);
      step(1);
    end
    send_rsp(1'b1, 64'hA0);
    send_rsp(1'b1, 64'hB0);
    rd_check("err_addr_lo", ETH_IDMA_REG_ERR_ADDR_LO, 32'hA0);
    rd_check("err_addr_hi", ETH_IDMA_REG_ERR_ADDR_HI, 32'h0);
    rd_check("err_status", ETH_IDMA_REG_STATUS, 32'h0000_0004);
    rd_check("err_done", ETH_IDMA_REG_DONE_CNT, 32'd8);
    wr_ok("err_clr", ETH_IDMA_REG_CTRL, 32'hC);
    rd_check("err_addr_cleared", ETH_IDMA_REG_ERR_ADDR_LO, 32'h0);
    rd_check("err_status_cleared", ETH_IDMA_REG_STATUS, 32'h0);

    // Rejected accesses
    bus.req_ready_i = 1'b0;
    wr_ok("len_zero", ETH_IDMA_REG_LEN, 32'h0);
    bus_write(ETH_IDMA_REG_CTRL, 32'h5, 4'hF, err);
    check1("go_len0_err", err, 1'b1);
    check1("go_len0_no_valid", bus.req_valid_o, 1'b0);
    rd_check("go_len0_issue", ETH_IDMA_REG_ISSUE_CNT, 32'd8);
    wr_ok("len_64", ETH_IDMA_REG_LEN, 32'd64);
    t1_req = make_req(64'h1000, 64'h8000_0000, 32'd64, 6'h0A);
    exp_req_q.push_back(t1_req);
    wr_ok("pend_go", ETH_IDMA_REG_CTRL, 32'h5);
    bus_write(ETH_IDMA_REG_DST_LO, 32'hDEAD, 4'hF, err);
    check1("pend_wr_err", err, 1'b1);
    check1("pend_still_valid", bus.req_valid_o, 1'b1);
    check("pend_req_stable", 192'(bus.idma_req_o), 192'(t1_req));
    bus.req_ready_i = 1'b1;
    step(1);
    bus.req_ready_i = 1'b0;
    rd_check("pend_dst_kept", ETH_IDMA_REG_DST_LO, 32'h8000_0000);
    bus_read(32'h40, data, err);
    check1("unmapped_err", err, 1'b1);
    check32("unmapped_rdata", data, 32'h0);
    rd_check("ctrl_reads_0", ETH_IDMA_REG_CTRL, 32'h0);
    rd_check("unmapped_no_change", ETH_IDMA_REG_STATUS, 32'h0000_0101);
    send_rsp(1'b0, 64'h0);

    // Reset during PEND withdraws the request
    wr_ok("rst_go", ETH_IDMA_REG_CTRL, 32'h5);
    check1("rst_pend_valid", bus.req_valid_o, 1'b1);
    rst_i = 1'b1;
    step(1);
    check1("rst_withdraw", bus.req_valid_o, 1'b0);
    check1("rst_busy_clear", busy, 1'b0);
    rst_i = 1'b0;
    rd_check("rst_issue", ETH_IDMA_REG_ISSUE_CNT, 32'h0);
    rd_check("rst_done_cnt", ETH_IDMA_REG_DONE_CNT, 32'h0);
    rd_check("rst_status_clr", ETH_IDMA_REG_STATUS, 32'h0);
    rd_check("rst_src_clr", ETH_IDMA_REG_SRC_LO, 32'h0);
    check32("scoreboard_empty", 32'(exp_req_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
